// File: rtl/urv_console_pkg.sv
// Shared definitions for the uRV console / test-status peripheral:
// register offsets, STATUS bit layout and the bus FSM states.
package urv_console_pkg;

    // Word offsets inside the 16-byte register window (dm_addr_i[3:2])
    localparam logic [1:0] OFF_TX        = 2'd0;
    localparam logic [1:0] OFF_TEST_DONE = 2'd1;
    localparam logic [1:0] OFF_STATUS    = 2'd2;
    localparam logic [1:0] OFF_CTRL      = 2'd3;

    // STATUS register layout
    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_DONE    = 2;
    localparam int STAT_CNT_LSB = 8;

    // Bus-side FSM
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_SPACE,
        S_ACK
    } state_e;

endpackage

// File: rtl/urv_console_fifo.sv
// Synchronous show-ahead FIFO for the console TX path. The head entry is
// presented combinationally; a pop on an empty FIFO is ignored and a push
// into a full FIFO is only taken when a pop frees a slot in the same cycle.
// Flush has priority over push and pop.
module urv_console_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = count_q;
    // Head is forced to zero when empty so the stale storage never leaks out
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage write; contents need no reset since reads are gated by empty
    always_ff @(posedge clk_i) begin
        if (do_push && !flush) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/urv_console_port.sv
// Memory-mapped console and test-status port on the uRV data bus.
// TX stores are queued into a FIFO drained over a ready/valid byte stream;
// TEST_DONE latches a completion code; STATUS exposes FIFO state for polling.
module urv_console_port
    import urv_console_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0010_0000,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_store_i,
    input  logic        dm_load_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_store_done_o,
    output logic        dm_load_done_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic        test_done_o,
    output logic [31:0] test_code_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e        state_q, state_d;
    logic          ack_load_q, ack_load_d;
    logic [31:0]   load_data_q, load_data_d;
    logic          test_done_q, test_done_d;
    logic [31:0]   test_code_q, test_code_d;

    logic          hit;
    logic [1:0]    offset;
    logic          push, pop, flush, full, empty, space;
    logic [CW-1:0] count;
    logic [31:0]   status_word;
    logic [31:0]   read_word;
    logic          unused_bits;

    assign hit         = (dm_addr_i[31:4] == BASE_ADDR[31:4]);
    assign offset      = dm_addr_i[3:2];
    assign tx_valid_o  = !empty;
    assign pop         = tx_valid_o && tx_ready_i;
    // A slot is available if not full, or the sink frees one this cycle
    assign space       = !full || pop;
    assign unused_bits = ^{dm_data_select_i[3:1], dm_addr_i[1:0]};

    urv_console_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (dm_data_s_i[7:0]),
        .rd_data (tx_data_o),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // Readback mux: STATUS and TEST_DONE carry data, TX/CTRL read as zero
    always_comb begin
        status_word                       = '0;
        status_word[STAT_FULL]            = full;
        status_word[STAT_EMPTY]           = empty;
        status_word[STAT_DONE]            = test_done_q;
        status_word[STAT_CNT_LSB +: CW]   = count;
        read_word                         = '0;
        case (offset)
            OFF_TEST_DONE: read_word = test_code_q;
            OFF_STATUS:    read_word = status_word;
            default:       read_word = '0;
        endcase
    end

    // Bus FSM: decode, perform the access, then acknowledge for one cycle
    always_comb begin
        state_d     = state_q;
        ack_load_d  = ack_load_q;
        load_data_d = load_data_q;
        test_done_d = test_done_q;
        test_code_d = test_code_q;
        push        = 1'b0;
        flush       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dm_store_i && hit) begin
                    ack_load_d = 1'b0;
                    state_d    = S_ACK;
                    case (offset)
                        OFF_TX: begin
                            if (dm_data_select_i[0]) begin
                                if (space) push = 1'b1;
                                else       state_d = S_WAIT_SPACE;
                            end
                        end
                        OFF_TEST_DONE: begin
                            test_code_d = dm_data_s_i;
                            test_done_d = 1'b1;
                        end
                        OFF_CTRL: begin
                            if (dm_data_s_i[0]) begin
                                flush       = 1'b1;
                                test_done_d = 1'b0;
                                test_code_d = '0;
                            end
                        end
                        default: ;
                    endcase
                end else if (dm_load_i && hit) begin
                    ack_load_d  = 1'b1;
                    load_data_d = read_word;
                    state_d     = S_ACK;
                end
            end
            S_WAIT_SPACE: begin
                if (!dm_store_i) begin
                    state_d = S_IDLE;
                end else if (space) begin
                    push    = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, response and test-status registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            ack_load_q  <= 1'b0;
            load_data_q <= '0;
            test_done_q <= 1'b0;
            test_code_q <= '0;
        end else begin
            state_q     <= state_d;
            ack_load_q  <= ack_load_d;
            load_data_q <= load_data_d;
            test_done_q <= test_done_d;
            test_code_q <= test_code_d;
        end
    end

    assign dm_store_done_o = (state_q == S_ACK) && !ack_load_q;
    assign dm_load_done_o  = (state_q == S_ACK) && ack_load_q;
    assign dm_data_l_o     = load_data_q;
    assign test_done_o     = test_done_q;
    assign test_code_o     = test_code_q;

endmodule

// File: doc/urv_console_port.md
# urv_console_port

Memory-mapped console and test-status peripheral on the uRV data-memory bus, downstream of the CPU's dm_* port. Accepts byte stores to a TX register into a FIFO, drains them over a ready/valid byte stream to a UART or host sink, and latches a test-complete code written by ISA test programs. Readback provides FIFO status so firmware can poll instead of stalling.

## Interface
- BASE_ADDR, 32'h0010_0000, base of 16-byte register window (bits [3:0] must be 0)
- FIFO_DEPTH, 16, TX FIFO entries; power of two, >= 2
- clk_i  in  1  system clock
- rst_n_i  in  1  reset; asynchronous, active-low
- dm_addr_i  in  32  byte address from CPU
- dm_data_s_i  in  32  store data
- dm_data_select_i  in  4  byte-lane enables
- dm_store_i  in  1  store request; held with stable addr/data until dm_store_done_o
- dm_load_i  in  1  load request; held until dm_load_done_o
- dm_data_l_o  out  32  load data, valid with dm_load_done_o
- dm_store_done_o  out  1  one-cycle store acknowledge
- dm_load_done_o  out  1  one-cycle load acknowledge
- tx_data_o  out  8  FIFO head byte
- tx_valid_o  out  1  FIFO non-empty
- tx_ready_i  in  1  sink accepts tx_data_o when tx_valid_o && tx_ready_i
- test_done_o  out  1  sticky test-complete flag
- test_code_o  out  32  last code written to TEST_DONE

## Operation
- Match: dm_addr_i[31:4] == BASE_ADDR[31:4]; offset = dm_addr_i[3:2]. Unmatched requests ignored, no acknowledge.
- Offset 0 TX (W): push dm_data_s_i[7:0] if dm_data_select_i[0]; lane 0 off -> acknowledge, no push. Read returns 0.
- Offset 1 TEST_DONE (W): test_code_o <= dm_data_s_i (all 32 bits, lanes ignored); test_done_o <= 1. Rewrite overwrites code, flag stays 1. Read returns test_code_o.
- Offset 2 STATUS (R): bit0 full, bit1 empty, bit2 test_done_o, bits[15:8] entry count; other bits 0. Writes acknowledged, no effect.
- Offset 3 CTRL (W): bit0=1 flushes FIFO and clears test_done_o/test_code_o. Read returns 0.
- FSM states IDLE, WAIT_SPACE, ACK:
  - IDLE: matched TX store with space (not full, or pop this cycle) -> push, ACK. TX store when full with no pop -> WAIT_SPACE. Any other matched store/load -> perform, ACK.
  - WAIT_SPACE: push on first cycle with space -> ACK. dm_store_i dropping -> IDLE, no push.
  - ACK: assert dm_store_done_o or dm_load_done_o for one cycle -> IDLE; requests ignored in this cycle.
- Simultaneous push+pop when full: both occur, count unchanged. Push+pop when empty: push only (no fall-through), tx_valid_o next cycle.
- CTRL flush same cycle as pop: flush wins, count 0. Flush uses the store's own cycle; no push that cycle.
- Concurrent dm_store_i and dm_load_i: store served, load waits.

## Timing
- Reset (async, any state): FSM IDLE, FIFO empty, all outputs 0; tx_valid_o falls with reset assertion, buffered bytes lost.
- Store latency: accepted in cycle N -> dm_store_done_o high in N+1; pushed byte on tx_data_o/tx_valid_o from N+1 if FIFO was empty.
- Load latency: request in IDLE cycle N -> dm_data_l_o registered, dm_load_done_o high in N+1; STATUS reflects state at end of cycle N.
- Back-to-back accesses: one access per 2 cycles minimum (IDLE, ACK).
- Pop: on cycle with tx_valid_o && tx_ready_i, head advances; next byte visible following cycle. Sustained one byte/cycle.
- Count width $clog2(FIFO_DEPTH)+1, zero-extended into STATUS[15:8]; pointers wrap modulo FIFO_DEPTH.

## Structure
- Package urv_console_pkg: register offsets (TX, TEST_DONE, STATUS, CTRL), STATUS bit positions, FSM state enum.
- Sub-module urv_console_fifo: synchronous show-ahead FIFO (push, pop, flush, full, empty, count), same clk_i/rst_n_i.
- Top holds address decode, FSM, test registers, readback mux.

## Test plan
- Reset then store 0x41 to 0x100000, tx_ready_i=1 -> dm_store_done_o at N+1, tx_data_o=0x41 valid one cycle, STATUS reads empty=1.
- tx_ready_i=0, 17 stores of 0x30..0x40 -> first 16 ack; 17th stalls in WAIT_SPACE until tx_ready_i pulse, then ack; sink sees 0x30..0x40 in order.
- Store 0xDEAD_BEEF to 0x100004 -> test_done_o=1, test_code_o=0xDEADBEEF; read 0x100004 returns 0xDEADBEEF; read 0x100008 shows bit2=1.
- Fill 3 bytes, write 1 to 0x10000C -> count 0, tx_valid_o=0, test_done_o=0.
- FIFO full, tx_ready_i=1 and TX store same cycle -> ack at N+1, count stays 16.
- Assert rst_n_i low mid-stall in WAIT_SPACE with 5 bytes buffered -> outputs 0 immediately; after release, STATUS reads empty=1, count 0.
